// File: rtl/adder_arbiter.sv
// adder_arbiter
//    Two-requester arbiter in front of a registered W-bit adder.  A winner is
//    chosen in IDLE; its operands and id are captured, summed in CALC and
//    presented in RESP until the consumer takes the result.
//
//    Arbitration: FIXED_PRIO=0 gives round-robin (last-grant pointer resets
//    to 1, so requester 0 wins the first contention); FIXED_PRIO=1 makes
//    requester 0 always win.
//
//    Optional feature: define ADDER_ARBITER_CARRY_EN to register the carry
//    out of the sum on res_carry.  Undefined, res_carry is tied to 0 and no
//    carry register exists.
//
//    Ports
//       clk         sole clock, rising edge
//       rst         asynchronous, active-high reset
//       req_valid   [1:0] request valid, bit i = requester i
//       req_ready   [1:0] grant, one-hot or zero, combinational in IDLE
//       req_a0/b0   requester 0 operands (W bits)
//       req_a1/b1   requester 1 operands (W bits)
//       res_valid   result valid (RESP only)
//       res_ready   result consumer ready
//       res_data    (a + b) mod 2^W
//       res_id      requester that owns res_data
//       res_carry   carry out of the sum, or 0 when the feature is off
//       busy        high outside IDLE
//       op_count    completed results, wraps at 256
//
//    state | meaning
//    ------+-------------------------------------------------------------
//    IDLE  | waiting for a request; grants one requester combinationally
//    CALC  | captured operands are summed into the result register
//    RESP  | result held on res_* until res_ready

module adder_arbiter #(
   parameter int W          = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [W-1:0] req_a0,
   input  logic [W-1:0] req_b0,
   input  logic [W-1:0] req_a1,
   input  logic [W-1:0] req_b1,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
   output logic         res_id,
   output logic         res_carry,
   output logic         busy,
   output logic [7:0]   op_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic         id_q, id_d;
   logic         last_q, last_d;
   logic [W-1:0] data_q, data_d;
   logic [7:0]   op_q, op_d;
   logic [1:0]   grant;

   // Winner selection.  With both valid, round-robin favours the requester
   // that was not granted last; fixed priority always favours requester 0.
   always_comb begin
      grant = 2'b00;
      unique case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11: begin
            if ((FIXED_PRIO != 0) || last_q) grant = 2'b01;
            else                             grant = 2'b10;
         end
         default: grant = 2'b00;
      endcase
   end

   // Gated by rst as well, so no grant is visible while reset is held.
   assign req_ready = ((state_q == S_IDLE) && !rst) ? grant : 2'b00;

`ifdef ADDER_ARBITER_CARRY_EN
   logic [W:0] sum_full;
   logic       carry_q, carry_d;

   assign sum_full = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      carry_d = carry_q;
      if (state_q == S_CALC) carry_d = sum_full[W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) carry_q <= 1'b0;
      else     carry_q <= carry_d;
   end

   assign res_carry = carry_q;
`else
   logic [W-1:0] sum_full;

   assign sum_full  = a_q + b_q;
   assign res_carry = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      last_d  = last_q;
      data_d  = data_q;
      op_d    = op_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               a_d     = grant[1] ? req_a1 : req_a0;
               b_d     = grant[1] ? req_b1 : req_b0;
               id_d    = grant[1];
               last_d  = grant[1];
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            data_d  = sum_full[W-1:0];
            state_d = S_RESP;
         end
         S_RESP: begin
            if (res_ready) begin
               op_d    = op_q + 8'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         data_q  <= '0;
         op_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         last_q  <= last_d;
         data_q  <= data_d;
         op_q    <= op_d;
      end
   end

   assign res_valid = (state_q == S_RESP);
   assign res_data  = data_q;
   assign res_id    = id_q;
   assign busy      = (state_q != S_IDLE);
   assign op_count  = op_q;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

   localparam int W          = 8;
   localparam int FIXED_PRIO = 0;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic         res_id;
   logic         res_carry;
   logic         busy;
   logic [7:0]   op_count;

   adder_arbiter #(.W(W), .FIXED_PRIO(FIXED_PRIO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_carry (res_carry),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] d;
      logic         id;
      logic         c;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   logic last_m      = 1'b1;
   logic [7:0] op_m  = 8'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic pick(input logic [1:0] v);
      if (v == 2'b11) return (FIXED_PRIO != 0) ? 1'b0 : ~last_m;
      return v[1] && !v[0];
   endfunction

   // Entered and left at posedge+1 with the DUT in IDLE.
   task automatic run_txn(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1, input int stall,
                          output logic got);
      logic   win;
      logic [8:0] s;
      exp_t   e;
      req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
      res_ready = 1'b0;
      #1;
      win = pick(v);
      got = req_ready[1];
      check("grant", {30'd0, req_ready}, win ? 32'd2 : 32'd1);
      s = win ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
      e.d  = s[7:0];
      e.id = win;
`ifdef ADDER_ARBITER_CARRY_EN
      e.c  = s[8];
`else
      e.c  = 1'b0;
`endif
      sb.push_back(e);
      last_m = win;
      @(posedge clk); #1;
      check("calc_res_valid", {31'd0, res_valid}, 32'd0);
      check("calc_req_ready", {30'd0, req_ready}, 32'd0);
      check("calc_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      check("resp_res_valid", {31'd0, res_valid}, 32'd1);
      check("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("res_data", {24'd0, res_data}, {24'd0, e.d});
         check("res_id", {31'd0, res_id}, {31'd0, e.id});
         check("res_carry", {31'd0, res_carry}, {31'd0, e.c});
         for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("stall_res_valid", {31'd0, res_valid}, 32'd1);
            check("stall_res_data", {24'd0, res_data}, {24'd0, e.d});
            check("stall_res_id", {31'd0, res_id}, {31'd0, e.id});
            check("stall_req_ready", {30'd0, req_ready}, 32'd0);
            check("stall_op_count", {24'd0, op_count}, {24'd0, op_m});
         end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      op_m = op_m + 8'd1;
      check("op_count", {24'd0, op_count}, {24'd0, op_m});
      check("idle_res_valid", {31'd0, res_valid}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
      check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
      check({tag, "_res_data"},  {24'd0, res_data},  32'd0);
      check({tag, "_res_id"},    {31'd0, res_id},    32'd0);
      check({tag, "_res_carry"}, {31'd0, res_carry}, 32'd0);
      check({tag, "_busy"},      {31'd0, busy},      32'd0);
      check({tag, "_op_count"},  {24'd0, op_count},  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      rst = 1'b1; req_valid = 2'b11; res_ready = 1'b0;
      req_a0 = 8'h00; req_b0 = 8'h00; req_a1 = 8'h00; req_b1 = 8'h00;
      #2;
      check_reset_outputs("rst0");
      @(posedge clk); @(posedge clk); #1;
      check_reset_outputs("rst1");
      req_valid = 2'b00;
      rst = 1'b0;
      #1;
      check("idle_none_ready", {30'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      check("idle_none_busy", {31'd0, busy}, 32'd0);
      check("idle_none_valid", {31'd0, res_valid}, 32'd0);

      // single request and overflow
      run_txn(2'b01, 8'h12, 8'h34, 8'h00, 8'h00, 0, got);
      run_txn(2'b10, 8'h00, 8'h00, 8'hF0, 8'h20, 0, got);

      // contention: both held valid for four transactions
      for (int i = 0; i < 4; i++) begin
         run_txn(2'b11, 8'(i), 8'h11, 8'h80 + 8'(i), 8'h90, 0, got);
         check("contention_order", {31'd0, got}, (FIXED_PRIO != 0) ? 32'd0 : 32'(i % 2));
      end

      // backpressure
      run_txn(2'b01, 8'hA5, 8'h5A, 8'h00, 8'h00, 5, got);
      run_txn(2'b10, 8'h00, 8'h00, 8'hFF, 8'h01, 3, got);

      // reset while in CALC, pointer steered toward requester 1 first
      run_txn(2'b01, 8'h01, 8'h02, 8'h00, 8'h00, 0, got);
      req_valid = 2'b11; req_a0 = 8'h33; req_b0 = 8'h44; req_a1 = 8'hEE; req_b1 = 8'h22;
      #1;
      check("pre_abort_grant", {30'd0, req_ready}, (FIXED_PRIO != 0) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
      check("abort_in_calc", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("abort");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("abort_no_valid", {31'd0, res_valid}, 32'd0);
      end
      rst = 1'b0;
      sb.delete();
      last_m = 1'b1;
      op_m = 8'd0;
      run_txn(2'b11, 8'h33, 8'h44, 8'hEE, 8'h22, 0, got);
      check("post_reset_winner", {31'd0, got}, 32'd0);

      // 256 transactions from reset: op_count returns to 0
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_m = 1'b1;
      op_m = 8'd0;
      for (int i = 0; i < 256; i++) begin
         run_txn(2'(1 + (i % 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, got);
      end
      check("op_count_wrap", {24'd0, op_count}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
